// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR output stages.
//   - FIR_IN_WIDTH_DEF / FIR_OUT_WIDTH_DEF : default sample widths
//   - clog2(n)                             : ceiling log2 (clog2(1) == 0)
//   - sat_max(w) / sat_min(w)              : two's-complement limits of a
//                                            w-bit signed value
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_IN_WIDTH_DEF  = 16;
  localparam int FIR_OUT_WIDTH_DEF = 8;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// -----------------------------------------------------------------------------
// fir_round_sat
// Combinational scaler: arithmetic right shift by SHIFT with round-half-up
// (toward +inf), then saturation to a signed OUT_WIDTH result.
//
// Parameters:
//   AW        width of the signed input sum (must carry one guard bit so the
//             rounding bias cannot overflow)
//   SHIFT     right-shift amount, 0..AW-2
//   OUT_WIDTH signed result width
// Ports:
//   sum_i  in   AW         signed sum to scale
//   res_o  out  OUT_WIDTH  rounded, saturated result
//   sat_o  out  1          result was clamped to min or max
// -----------------------------------------------------------------------------
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int AW        = 19,
  parameter int SHIFT     = 2,
  parameter int OUT_WIDTH = 8
) (
  input  logic signed [AW-1:0]        sum_i,
  output logic signed [OUT_WIDTH-1:0] res_o,
  output logic                        sat_o
);

  // Compare in a width that holds both the scaled sum and the output limits.
  localparam int WW = ((AW > OUT_WIDTH) ? AW : OUT_WIDTH) + 1;
  localparam logic signed [WW-1:0] MAX_V = WW'(sat_max(OUT_WIDTH));
  localparam logic signed [WW-1:0] MIN_V = WW'(sat_min(OUT_WIDTH));

  logic signed [AW-1:0] scaled;
  logic signed [WW-1:0] scaled_ext;

  generate
    if (SHIFT > 0) begin : g_round
      // Adding half an LSB before the floor-shift rounds ties toward +inf.
      localparam logic [AW-1:0] HALF = AW'(64'd1 << (SHIFT - 1));
      logic signed [AW-1:0] biased;
      assign biased = sum_i + $signed(HALF);
      assign scaled = biased >>> SHIFT;
    end else begin : g_pass
      assign scaled = sum_i;
    end
  endgenerate

  assign scaled_ext = {{(WW - AW){scaled[AW-1]}}, scaled};

  always_comb begin
    res_o = scaled_ext[OUT_WIDTH-1:0];
    sat_o = 1'b0;
    if (scaled_ext > MAX_V) begin
      res_o = MAX_V[OUT_WIDTH-1:0];
      sat_o = 1'b1;
    end else if (scaled_ext < MIN_V) begin
      res_o = MIN_V[OUT_WIDTH-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/fir_out_decimator.sv
// -----------------------------------------------------------------------------
// fir_out_decimator
// Integrate-and-dump decimator for the full-precision FIR output. Every DECIM
// accepted samples are summed, scaled (>>> SHIFT, round half up), saturated to
// OUT_WIDTH and pushed into a 2-entry valid/ready output buffer.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          input sample present
//   in_data    in   IN_WIDTH   signed input sample
//   in_ready   out  1          sample accepted this cycle (registered state only)
//   out_valid  out  1          output buffer non-empty
//   out_data   out  OUT_WIDTH  signed decimated sample at buffer head
//   out_ready  in   1          downstream accepts out_data
//   sat_seen   out  1          sticky: some output saturated since reset
// -----------------------------------------------------------------------------
module fir_out_decimator
  import fir_pkg::*;
#(
  parameter int IN_WIDTH  = FIR_IN_WIDTH_DEF,
  parameter int OUT_WIDTH = FIR_OUT_WIDTH_DEF,
  parameter int DECIM     = 4,
  parameter int SHIFT     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data,
  input  logic                        out_ready,
  output logic                        sat_seen
);

  localparam int ACC_GROWTH = clog2(DECIM);
  // One extra guard bit keeps the rounding bias from overflowing the sum.
  localparam int AW  = IN_WIDTH + ACC_GROWTH + 1;
  localparam int PHW = (ACC_GROWTH > 0) ? ACC_GROWTH : 1;
  localparam logic [PHW-1:0] PH_LAST = PHW'(DECIM - 1);

  // Registered state
  logic [PHW-1:0]              ph_q,     ph_d;
  logic signed [AW-1:0]        acc_q,    acc_d;
  logic signed [OUT_WIDTH-1:0] buf0_q,   buf0_d;
  logic signed [OUT_WIDTH-1:0] buf1_q,   buf1_d;
  logic                        wr_ptr_q, wr_ptr_d;
  logic                        rd_ptr_q, rd_ptr_d;
  logic [1:0]                  count_q,  count_d;
  logic                        sat_q,    sat_d;

  // Handshake / datapath intermediates
  logic                        ph_last;
  logic                        in_fire;
  logic                        push;
  logic                        pop;
  logic signed [AW-1:0]        in_ext;
  logic signed [AW-1:0]        acc_base;
  logic signed [AW-1:0]        sum;
  logic signed [OUT_WIDTH-1:0] rs_data;
  logic                        rs_sat;

  // ---- Handshake: depends only on registered state ----
  // in_ready drops only when the next sample would complete a group and the
  // buffer has no room; partial-group samples are always accepted.
  assign ph_last   = (ph_q == PH_LAST);
  assign in_ready  = !(ph_last && (count_q == 2'd2));
  assign out_valid = (count_q != 2'd0);
  assign in_fire   = in_valid && in_ready;
  assign push      = in_fire && ph_last;
  assign pop       = out_valid && out_ready;

  // ---- Accumulate: ph==0 starts a fresh group, so the old acc is ignored ----
  assign in_ext   = {{(AW - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign acc_base = (ph_q == '0) ? '0 : acc_q;
  assign sum      = acc_base + in_ext;

  // ---- Scale and saturate the completed group sum ----
  fir_round_sat #(
    .AW        (AW),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .sum_i (sum),
    .res_o (rs_data),
    .sat_o (rs_sat)
  );

  // ---- Next-state logic ----
  always_comb begin
    ph_d     = ph_q;
    acc_d    = acc_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sat_d    = sat_q;

    if (in_fire) begin
      if (ph_last) begin
        // The completing sample goes straight to the buffer; acc is left
        // alone because the next group reloads it at ph==0.
        ph_d = '0;
      end else begin
        ph_d  = ph_q + PHW'(1);
        acc_d = sum;
      end
    end

    if (push) begin
      if (wr_ptr_q) begin
        buf1_d = rs_data;
      end else begin
        buf0_d = rs_data;
      end
      wr_ptr_d = ~wr_ptr_q;
      sat_d    = sat_q | rs_sat;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // ---- State registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q     <= '0;
      acc_q    <= '0;
      buf0_q   <= '0;
      buf1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      sat_q    <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      acc_q    <= acc_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
    end
  end

  // ---- Outputs ----
  assign out_data = rd_ptr_q ? buf1_q : buf0_q;
  assign sat_seen = sat_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// -----------------------------------------------------------------------------
// tb_fir_out_decimator
// Self-checking bench for fir_out_decimator with default parameters
// (IN_WIDTH=16, OUT_WIDTH=8, DECIM=4, SHIFT=2). A reference model groups
// accepted samples in fours and scales each group sum with real-valued
// round-half-up arithmetic and clamping.
// -----------------------------------------------------------------------------
module tb_fir_out_decimator;

  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int DEC   = 4;
  localparam int SH    = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [IN_W-1:0]  in_data = '0;
  logic                    in_ready;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_ready = 1'b0;
  logic                    sat_seen;

  int checks = 0;
  int fails  = 0;

  int got[$];
  int exp_q[$];
  int m_sum = 0;
  int m_n   = 0;
  bit m_sat = 1'b0;

  always #5 clk = ~clk;

  fir_out_decimator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sat_seen  (sat_seen)
  );

  // Reference: group sum / 2^SH rounded half up, then clamped to OUT_W bits.
  function automatic int ref_scale(input int s, output bit clamped);
    int r;
    int hi;
    int lo;
    hi = (2 ** (OUT_W - 1)) - 1;
    lo = -(2 ** (OUT_W - 1));
    r = int'($floor(real'(s) / real'(2 ** SH) + 0.5));
    clamped = 1'b0;
    if (r > hi) begin
      r = hi;
      clamped = 1'b1;
    end else if (r < lo) begin
      r = lo;
      clamped = 1'b1;
    end
    return r;
  endfunction

  // Observe transfers midway between active edges.
  initial begin
    bit c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_sum = 0;
        m_n   = 0;
        m_sat = 1'b0;
      end else begin
        if (out_valid && out_ready) got.push_back(int'(out_data));
        if (in_valid && in_ready) begin
          m_sum = m_sum + int'(in_data);
          m_n   = m_n + 1;
          if (m_n == DEC) begin
            exp_q.push_back(ref_scale(m_sum, c));
            m_sat = m_sat | c;
            m_sum = 0;
            m_n   = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until it is accepted (bounded).
  task automatic send(input int v);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = IN_W'(v);
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_queues();
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b required=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b required=1", in_ready); end
    checks++; if (out_data !== 8'sd0) begin fails++; $display("FAIL reset_out_data got=%0d required=0", out_data); end
    checks++; if (sat_seen !== 1'b0) begin fails++; $display("FAIL reset_sat_seen got=%0b required=0", sat_seen); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_queues();
    out_ready = 1'b1;
    repeat (3) send(100);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got=%0b required=0", out_valid); end
    send(100);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency_valid got=%0b required=1", out_valid); end
    checks++; if (out_data !== 8'sd100) begin fails++; $display("FAIL basic_data got=%0d required=100", out_data); end
    repeat (3) tick();
    checks++; if (got.size() != 1) begin fails++; $display("FAIL basic_count got=%0d required=1", got.size()); end
    checks++; if (sat_seen !== 1'b0) begin fails++; $display("FAIL basic_sat got=%0b required=0", sat_seen); end
  endtask

  task automatic test_rounding();
    int req[2];
    req = '{-3, 1};
    clear_queues();
    out_ready = 1'b1;
    send(-3); send(-3); send(-3); send(-2);
    send(1);  send(1);  send(0);  send(0);
    repeat (3) tick();
    checks++; if (got.size() != 2) begin fails++; $display("FAIL round_count got=%0d required=2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < got.size()) begin
        checks++; if (got[i] != req[i]) begin fails++; $display("FAIL round_value[%0d] got=%0d required=%0d", i, got[i], req[i]); end
      end
    end
  endtask

  task automatic test_saturation();
    int req[2];
    req = '{127, -128};
    clear_queues();
    out_ready = 1'b1;
    repeat (4) send(1000);
    tick();
    checks++; if (sat_seen !== 1'b1) begin fails++; $display("FAIL sat_set got=%0b required=1", sat_seen); end
    repeat (4) send(-1000);
    repeat (3) tick();
    checks++; if (got.size() != 2) begin fails++; $display("FAIL sat_count got=%0d required=2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < got.size()) begin
        checks++; if (got[i] != req[i]) begin fails++; $display("FAIL sat_value[%0d] got=%0d required=%0d", i, got[i], req[i]); end
      end
    end
    checks++; if (sat_seen !== 1'b1) begin fails++; $display("FAIL sat_sticky got=%0b required=1", sat_seen); end
  endtask

  task automatic test_backpressure();
    int req[3];
    req = '{3, 7, 11};
    clear_queues();
    out_ready = 1'b0;
    for (int i = 1; i <= 11; i++) send(i);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_low got=%0b required=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid got=%0b required=1", out_valid); end
    in_valid = 1'b1;
    in_data  = 16'sd12;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_hold got=%0b required=0", in_ready); end
    checks++; if (out_data !== 8'sd3) begin fails++; $display("FAIL bp_head_stable got=%0d required=3", out_data); end
    out_ready = 1'b1;
    send(12);
    repeat (5) tick();
    checks++; if (got.size() != 3) begin fails++; $display("FAIL bp_count got=%0d required=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        checks++; if (got[i] != req[i]) begin fails++; $display("FAIL bp_value[%0d] got=%0d required=%0d", i, got[i], req[i]); end
      end
    end
  endtask

  task automatic test_random();
    clear_queues();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom % 2) == 0;
      in_data   = IN_W'(int'($urandom_range(0, 4000)) - 2000);
      out_ready = ($urandom % 3) != 0;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    checks++; if (exp_q.size() < 20) begin fails++; $display("FAIL rand_groups got=%0d required>=20", exp_q.size()); end
    checks++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL rand_count got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) begin
        checks++; if (got[i] != exp_q[i]) begin fails++; $display("FAIL rand_value[%0d] got=%0d required=%0d", i, got[i], exp_q[i]); end
      end
    end
    checks++; if (sat_seen !== m_sat) begin fails++; $display("FAIL rand_sat got=%0b required=%0b", sat_seen, m_sat); end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    out_ready = 1'b1;
    send(50);
    send(50);
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid got=%0b required=0", out_valid); end
    checks++; if (sat_seen !== 1'b0) begin fails++; $display("FAIL rstmid_sat got=%0b required=0", sat_seen); end
    tick();
    rst_n = 1'b1;
    tick();
    repeat (4) send(8);
    repeat (3) tick();
    checks++; if (got.size() != 1) begin fails++; $display("FAIL rstmid_count got=%0d required=1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] != 8) begin fails++; $display("FAIL rstmid_value got=%0d required=8", got[0]); end
    end
    checks++; if (sat_seen !== 1'b0) begin fails++; $display("FAIL rstmid_sat_after got=%0b required=0", sat_seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/fir_out_decimator.md
# fir_out_decimator

Post-filter output stage that consumes the full-precision FIR output stream (signed, 2×DATA_WIDTH) and produces a reduced-rate, reduced-width sample stream. Each output is the integrate-and-dump sum of DECIM consecutive input samples, scaled by an arithmetic right shift with round-half-up and saturated to OUT_WIDTH. A 2-entry output buffer with valid/ready isolates downstream backpressure from the filter.

## Interface
- IN_WIDTH, 16, signed input sample width (FIR y_out width)
- OUT_WIDTH, 8, signed output sample width
- DECIM, 4, samples per output; legal 1..256
- SHIFT, 2, right-shift applied to the group sum; legal 0..IN_WIDTH+ACC_GROWTH-1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input sample present
- in_data  input  IN_WIDTH  signed input sample
- in_ready  output  1  stage accepts in_data this cycle
- out_valid  output  1  output buffer non-empty
- out_data  output  OUT_WIDTH  signed decimated sample (buffer head)
- out_ready  input  1  downstream accepts out_data
- sat_seen  output  1  sticky: some output saturated since reset

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- ACC_GROWTH = clog2(DECIM); accumulator width AW = IN_WIDTH + ACC_GROWTH + 1 (guard bit for rounding), sign-extended adds.
- Phase counter ph, 0..DECIM-1. On input transfer: ph==0 loads acc = in_data; else acc = acc + in_data. ph increments, wraps DECIM-1 -> 0.
- Completing transfer (ph==DECIM-1): sum = acc + in_data (for DECIM=1, sum = in_data); acc is not updated; result pushed into buffer.
- Scaling: if SHIFT>0, r = (sum + 2^(SHIFT-1)) >>> SHIFT, else r = sum. Round half toward +inf.
- Saturation: r > 2^(OUT_WIDTH-1)-1 -> max; r < -2^(OUT_WIDTH-1) -> min; else truncate to OUT_WIDTH. Any clamp sets sat_seen (cleared only by reset).
- in_ready = !(ph==DECIM-1 && count==2), from registered state only; no combinational path from out_ready or in_valid.
- Buffer: 2-entry FIFO, count 0..2. Push and pop in the same cycle with count≥1: count unchanged, order preserved. Push with count==2 is impossible (in_ready low).
- Non-completing input transfers are accepted even when buffer full.

## Timing
- Reset (async assert, sync release): ph=0, acc=0, count=0, out_valid=0, out_data=0, sat_seen=0, in_ready=1.
- Latency: completing input transfer in cycle t -> out_valid=1 with the result in cycle t+1 (buffer empty case).
- Throughput: one input per cycle; one output per DECIM cycles sustained with out_ready=1.
- in_ready falls the cycle after the state reaches ph==DECIM-1 with count==2; rises the cycle after the pop that makes count<2.
- out_data stable while out_valid && !out_ready.
- Reset mid-group: partial accumulation discarded; first post-reset sample starts a new group at ph=0; buffered outputs dropped.
- Gaps in in_valid do not affect grouping; ph advances only on transfers.

## Structure
- Shared package fir_pkg: clog2 function, sat_min/sat_max constant functions of width, common sample-width parameter defaults.
- One sub-module: fir_round_sat (combinational: AW-bit sum in, SHIFT/OUT_WIDTH parameters, OUT_WIDTH result plus sat flag out); reusable by other output stages.
- FIFO inline (two registers, rd/wr pointer bits, count).

## Test plan
- Defaults; four inputs 100, out_ready=1 -> sum 400, (400+2)>>>2 = 100; one output 100, one cycle after 4th transfer; sat_seen=0.
- Inputs -3,-3,-3,-2 -> sum -11, (-9)>>>2 = -3; inputs 1,1,0,0 -> (2+2)>>>2 = 1 (half rounds up).
- Four inputs 1000 -> 127, sat_seen=1; four inputs -1000 -> -128; sat_seen stays 1 until reset.
- out_ready=0, stream 12 inputs 1..12 -> outputs 3 ((10+2)>>>2), 7 (26+2=28>>>2) buffered; in_ready low with ph=3 of third group; raise out_ready -> 3, 7, then 11 ((42+2)>>>2) in order, no loss.
- Random in_valid gaps (~50%) with random out_ready; compare against a reference model of groups of 4 -> exact sequence match, no duplicates/drops.
- Assert rst_n low after 2 of 4 inputs (values 50,50), release, send 4 inputs of 8 -> only output 8; out_valid=0 and sat_seen=0 during reset.
